ysyx_22040386_lsu: RTL and testbench
====================================

Name: ysyx_22040386_lsu

Overview:
- Load/store unit directly upstream of the writeback mux.
- Takes the EXU address/result and store data, performs one memory transaction over a simple valid/ready request/response bus, and aligns and extends load data.
- Presents the result as rd_mem_data to writeback.
- One transaction in flight at a time; a 4-state FSM provides the back-pressure.

Parameters:
- ADDR_W, 64, width of address from EXU and on the memory bus.
- DATA_W, 64, data width; only 64 is supported and elaboration errors otherwise.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  EXU presents an instruction.
- in_ready  output  1  LSU can accept an instruction.
- mem_read  input  1  instruction is a load.
- mem_write  input  1  instruction is a store.
- funct3  input  3  RV64 load/store size/sign code.
- addr  input  ADDR_W  effective address (EXU result).
- wdata  input  64  store source register value.
- mem_req_valid  output  1  bus request valid.
- mem_req_ready  input  1  bus accepts request.
- mem_req_wen  output  1  1 = write, 0 = read.
- mem_req_addr  output  ADDR_W  8-byte-aligned address (addr with [2:0]=0).
- mem_req_wdata  output  64  lane-shifted store data.
- mem_req_wmask  output  8  byte-lane write enables.
- mem_rsp_valid  input  1  bus response (read data or write ack).
- mem_rsp_rdata  input  64  read data, full 8-byte word.
- out_valid  output  1  result available to WBU.
- out_ready  input  1  WBU consumes result.
- rd_mem_data  output  64  extended load data; 0 for stores and non-memory ops.
- lsu_err  output  1  misaligned access, illegal funct3, or read and write both set; valid with out_valid.

Behaviour:
- States: IDLE, REQ, WAIT, OUT. Reset is asynchronous and active-high.
- Reset values: state=IDLE, all outputs 0 (in_ready=1 once reset deasserts). Reset mid-transaction abandons the access. mem_rsp_valid is ignored in every state except WAIT, so stale responses after reset are dropped.
- in_ready = (state==IDLE). Accept when in_valid & in_ready; latch funct3, addr[2:0], read/write, and store lanes.
- Accept routing:
  - Neither read nor write: next state OUT, rd_mem_data=0, lsu_err=0.
  - Error (half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0; funct3=111 on a load; funct3 >=100 on a store; read&write both set): next state OUT, lsu_err=1, rd_mem_data=0, no bus activity.
  - Otherwise: next state REQ.
- REQ: mem_req_valid=1 with registered wen/addr/wdata/wmask, all held stable until mem_req_ready. On handshake go to WAIT and drop mem_req_valid.
- WAIT: on mem_rsp_valid capture data and go to OUT. A response is only legal at least one cycle after the request handshake.
- OUT: out_valid=1. rd_mem_data and lsu_err are held until out_ready, then go to IDLE. rd_mem_data is cleared to 0 on leaving OUT.
- Store lanes (off=addr[2:0]):
  - mem_req_wdata = wdata << 8*off.
  - wmask: SB 8'h01<<off, SH 8'h03<<off, SW 8'h0F<<off, SD 8'hFF.
- Load extraction: s = rdata >> 8*off, then:
  - LB: sext s[7:0]; LH: sext s[15:0]; LW: sext s[31:0]; LD: s.
  - LBU/LHU/LWU: zero-extend s[7:0] / s[15:0] / s[31:0].
- Latency (ready/rsp immediate): accept T; req T+1; rsp T+2; out_valid T+3. Non-memory or error ops: out_valid at T+1.
- Throughput: at most one instruction per 2 cycles (non-memory), one per 4 cycles (memory).

Decomposition:
- Shared package ysyx_22040386_lsu_pkg holds:
  - funct3 constants: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110; SB/SH/SW/SD share 000–011.
  - FSM state enum.
  - Function computing the store byte mask.
- One combinational sub-module, ysyx_22040386_lsu_ext: load shift plus sign/zero extension, (rdata, off, funct3) -> 64-bit result. It is reused by any future cache-bypass path.

Test Plan:
- LB addr=0x80000003, rdata=0x0000_0000_8000_0000 (byte 3 = 0x80) -> rd_mem_data=0xFFFF_FFFF_FFFF_FF80, lsu_err=0, out_valid at T+3.
- LWU addr=0x80000004, rdata=0xDEADBEEF_00000000 -> rd_mem_data=0x0000_0000_DEAD_BEEF; the same access with LW -> 0xFFFF_FFFF_DEAD_BEEF.
- SH addr=0x80000006, wdata=0x1234 -> mem_req_addr=0x80000000, wmask=8'hC0, wdata=0x1234_0000_0000_0000, wen=1; after ack rd_mem_data=0.
- LW addr=0x80000002 -> no mem_req_valid ever, out_valid at T+1, lsu_err=1, rd_mem_data=0.
- Back-pressure: mem_req_ready low 3 cycles, then out_ready low 2 cycles -> request fields stable throughout, in_ready=0 until the cycle after the out handshake, single bus request.
- Assert rst while in WAIT, then pulse mem_rsp_valid after release -> state IDLE, out_valid stays 0, response ignored; next LD completes normally.

Source files
------------

// File: rtl/ysyx_22040386_lsu_pkg.sv
// Shared definitions for the ysyx_22040386 load/store unit: funct3 codes,
// FSM state encoding and the byte-lane helper functions.
package ysyx_22040386_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } lsu_state_e;

    function automatic logic [7:0] store_mask(input logic [2:0] funct3, input logic [2:0] off);
        logic [7:0] mask;
        case (funct3)
            F3_SB:   mask = 8'h01 << off;
            F3_SH:   mask = 8'h03 << off;
            F3_SW:   mask = 8'h0F << off;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Size is encoded in funct3[1:0] for both signed and unsigned loads.
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [2:0] off);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_22040386_lsu_ext.sv
// Load data alignment: shifts the addressed bytes down to lane 0 and
// applies sign or zero extension according to funct3.
module ysyx_22040386_lsu_ext
    import ysyx_22040386_lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] result
);

    logic [63:0] shifted_s;

    assign shifted_s = rdata >> {off, 3'b000};

    // Select width and extension; undefined codes yield zero.
    always_comb begin
        result = 64'd0;
        case (funct3)
            F3_LB:   result = {{56{shifted_s[7]}},  shifted_s[7:0]};
            F3_LH:   result = {{48{shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   result = {{32{shifted_s[31]}}, shifted_s[31:0]};
            F3_LD:   result = shifted_s;
            F3_LBU:  result = {56'd0, shifted_s[7:0]};
            F3_LHU:  result = {48'd0, shifted_s[15:0]};
            F3_LWU:  result = {32'd0, shifted_s[31:0]};
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040386_lsu.sv
// Load/store unit: accepts one EXU op at a time, runs a single bus
// transaction through IDLE/REQ/WAIT/OUT and hands aligned data to writeback.
module ysyx_22040386_lsu
    import ysyx_22040386_lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [63:0]       mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [63:0]       mem_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       rd_mem_data,
    output logic              lsu_err
);

    if (DATA_W != 64) begin : g_bad_data_w
        $error("ysyx_22040386_lsu supports DATA_W == 64 only");
    end

    lsu_state_e        state_r;
    lsu_state_e        state_nx_s;
    logic              accept_s;
    logic              is_mem_s;
    logic              err_s;
    logic [2:0]        f3_r;
    logic [2:0]        off_r;
    logic              wen_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [63:0]       req_wdata_r;
    logic [7:0]        req_wmask_r;
    logic [63:0]       rd_data_r;
    logic              err_r;
    logic [63:0]       ext_data_s;

    assign accept_s = in_valid & in_ready;
    assign is_mem_s = mem_read | mem_write;
    assign err_s    = (mem_read & mem_write)
                    | (mem_read & (funct3 == 3'b111))
                    | (mem_write & (funct3 > F3_SD))
                    | (is_mem_s & addr_misaligned(funct3, addr[2:0]));

    // in_ready is held low while reset is asserted so nothing is offered then.
    assign in_ready      = (state_r == ST_IDLE) & ~rst;
    assign mem_req_valid = (state_r == ST_REQ);
    assign out_valid     = (state_r == ST_OUT);
    assign mem_req_wen   = wen_r;
    assign mem_req_addr  = req_addr_r;
    assign mem_req_wdata = req_wdata_r;
    assign mem_req_wmask = req_wmask_r;
    assign rd_mem_data   = rd_data_r;
    assign lsu_err       = err_r;

    ysyx_22040386_lsu_ext u_ext (
        .rdata  (mem_rsp_rdata),
        .off    (off_r),
        .funct3 (f3_r),
        .result (ext_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; errors and non-memory ops skip the bus entirely.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (err_s || !is_mem_s) begin
                        state_nx_s = ST_OUT;
                    end else begin
                        state_nx_s = ST_REQ;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_nx_s = ST_OUT;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Request fields, captured response and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_r        <= 3'd0;
            off_r       <= 3'd0;
            wen_r       <= 1'b0;
            req_addr_r  <= {ADDR_W{1'b0}};
            req_wdata_r <= 64'd0;
            req_wmask_r <= 8'd0;
            rd_data_r   <= 64'd0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        f3_r        <= funct3;
                        off_r       <= addr[2:0];
                        wen_r       <= mem_write;
                        req_addr_r  <= {addr[ADDR_W-1:3], 3'b000};
                        req_wdata_r <= mem_write ? (wdata << {addr[2:0], 3'b000}) : 64'd0;
                        req_wmask_r <= mem_write ? store_mask(funct3, addr[2:0]) : 8'd0;
                        rd_data_r   <= 64'd0;
                        err_r       <= err_s;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        rd_data_r <= wen_r ? 64'd0 : ext_data_s;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        rd_data_r <= 64'd0;
                        err_r     <= 1'b0;
                    end
                end
                default: begin
                    rd_data_r <= rd_data_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Scoreboard bench for ysyx_22040386_lsu: stimulus queues expected bus
// requests and results, one negedge monitor models the bus and checks both.
module tb_ysyx_22040386_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_wen;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_rdata = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] rd_mem_data;
    logic        lsu_err;

    typedef struct packed {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
    } req_exp_t;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } out_exp_t;

    req_exp_t req_q[$];
    out_exp_t out_q[$];

    int n_vec = 0;
    int n_miss = 0;

    int          req_hold_cfg = 0;
    int          out_hold_cfg = 0;
    bit          rsp_block = 1'b0;
    bit          rsp_inject = 1'b0;
    int          req_stall = 0;
    int          out_stall = 0;
    bit          req_seen = 1'b0;
    bit          out_seen = 1'b0;
    bit          rsp_due = 1'b0;
    logic [63:0] rsp_data = 64'd0;

    ysyx_22040386_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rd_mem_data   (rd_mem_data),
        .lsu_err       (lsu_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic wen, input logic [63:0] a, input logic [63:0] wd,
                           input logic [7:0] wm, input logic [63:0] rd);
        req_exp_t e;
        e.wen = wen; e.addr = a; e.wdata = wd; e.wmask = wm; e.rdata = rd;
        req_q.push_back(e);
    endtask

    task automatic exp_out(input logic [63:0] d, input logic e);
        out_exp_t o;
        o.data = d; o.err = e;
        out_q.push_back(o);
    endtask

    // Bus model and result monitor: both compare against the queue heads.
    always @(negedge clk) begin
        if (rst) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            out_ready     = 1'b0;
            rsp_due       = 1'b0;
            req_seen      = 1'b0;
            out_seen      = 1'b0;
        end else begin
            mem_rsp_valid = 1'b0;
            if (rsp_due && !rsp_block) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rsp_data;
                rsp_due       = 1'b0;
            end else if (rsp_inject) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (mem_req_valid) begin
                if (!req_seen) begin
                    req_seen  = 1'b1;
                    req_stall = req_hold_cfg;
                end
                mem_req_ready = (req_stall == 0);
                if (req_q.size() == 0) begin
                    check("unexpected_req_valid", 64'(mem_req_valid), 64'd0);
                end else begin
                    check("req_wen",   64'(mem_req_wen),   64'(req_q[0].wen));
                    check("req_addr",  mem_req_addr,       req_q[0].addr);
                    check("req_wdata", mem_req_wdata,      req_q[0].wdata);
                    check("req_wmask", 64'(mem_req_wmask), 64'(req_q[0].wmask));
                end
                if (mem_req_ready) begin
                    if (req_q.size() != 0) begin
                        rsp_data = req_q[0].rdata;
                        void'(req_q.pop_front());
                    end else begin
                        rsp_data = 64'd0;
                    end
                    rsp_due  = 1'b1;
                    req_seen = 1'b0;
                end else begin
                    req_stall--;
                end
            end else begin
                mem_req_ready = 1'b0;
            end
            if (out_valid) begin
                if (!out_seen) begin
                    out_seen  = 1'b1;
                    out_stall = out_hold_cfg;
                end
                out_ready = (out_stall == 0);
                if (out_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("rd_mem_data", rd_mem_data,   out_q[0].data);
                    check("lsu_err",     64'(lsu_err),  64'(out_q[0].err));
                end
                if (out_ready) begin
                    if (out_q.size() != 0) void'(out_q.pop_front());
                    out_seen = 1'b0;
                end else begin
                    out_stall--;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    task automatic run_op(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd,
                          input int exp_lat, input int exp_busy);
        int lat;
        int busy;
        int guard;
        @(negedge clk); #1;
        in_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        check({name, "_accept"}, 64'(in_ready), 64'd1);
        @(negedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
        check({name, "_out_latency"}, 64'(lat), 64'(exp_lat));
        busy = lat;
        while (!in_ready && busy < 60) begin
            @(negedge clk); #1;
            busy++;
        end
        check({name, "_busy_cycles"}, 64'(busy), 64'(exp_busy));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready",      64'(in_ready),      64'd0);
        check("rst_out_valid",     64'(out_valid),     64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_rd_mem_data",   rd_mem_data,        64'd0);
        check("rst_lsu_err",       64'(lsu_err),       64'd0);
        check("rst_wmask",         64'(mem_req_wmask), 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Loads
        exp_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_8000_0000);
        exp_out(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        run_op("lb", 1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'd0, 3, 4);
        exp_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_8000_0000);
        exp_out(64'h0000_0000_0000_0080, 1'b0);
        run_op("lbu", 1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'd0, 3, 4);
        exp_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'hDEAD_BEEF_0000_0000);
        exp_out(64'h0000_0000_DEAD_BEEF, 1'b0);
        run_op("lwu", 1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0, 3, 4);
        exp_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'hDEAD_BEEF_0000_0000);
        exp_out(64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
        run_op("lw", 1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'd0, 3, 4);
        exp_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_8765_0000);
        exp_out(64'hFFFF_FFFF_FFFF_8765, 1'b0);
        run_op("lh", 1'b1, 1'b0, 3'b001, 64'h8000_0002, 64'd0, 3, 4);
        exp_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_8765_0000);
        exp_out(64'h0000_0000_0000_8765, 1'b0);
        run_op("lhu", 1'b1, 1'b0, 3'b101, 64'h8000_0002, 64'd0, 3, 4);
        exp_req(1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF);
        exp_out(64'h0123_4567_89AB_CDEF, 1'b0);
        run_op("ld", 1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'd0, 3, 4);

        // Stores
        exp_req(1'b1, 64'h8000_0000, 64'h1234_0000_0000_0000, 8'hC0, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_out(64'd0, 1'b0);
        run_op("sh", 1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_1234, 3, 4);
        exp_req(1'b1, 64'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20, 64'd0);
        exp_out(64'd0, 1'b0);
        run_op("sb", 1'b0, 1'b1, 3'b000, 64'h8000_0005, 64'h0000_0000_0000_00AB, 3, 4);
        exp_req(1'b1, 64'h8000_0000, 64'hCAFE_F00D_0000_0000, 8'hF0, 64'd0);
        exp_out(64'd0, 1'b0);
        run_op("sw", 1'b0, 1'b1, 3'b010, 64'h8000_0004, 64'h0000_0000_CAFE_F00D, 3, 4);
        exp_req(1'b1, 64'h8000_0008, 64'h0102_0304_0506_0708, 8'hFF, 64'd0);
        exp_out(64'd0, 1'b0);
        run_op("sd", 1'b0, 1'b1, 3'b011, 64'h8000_0008, 64'h0102_0304_0506_0708, 3, 4);

        // Errors (no bus request expected) and non-memory op
        exp_out(64'd0, 1'b1);
        run_op("lw_misaligned", 1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 1, 2);
        exp_out(64'd0, 1'b1);
        run_op("ld_misaligned", 1'b1, 1'b0, 3'b011, 64'h8000_0004, 64'd0, 1, 2);
        exp_out(64'd0, 1'b1);
        run_op("sh_misaligned", 1'b0, 1'b1, 3'b001, 64'h8000_0001, 64'd5, 1, 2);
        exp_out(64'd0, 1'b1);
        run_op("load_f3_111", 1'b1, 1'b0, 3'b111, 64'h8000_0000, 64'd0, 1, 2);
        exp_out(64'd0, 1'b1);
        run_op("store_f3_100", 1'b0, 1'b1, 3'b100, 64'h8000_0000, 64'd7, 1, 2);
        exp_out(64'd0, 1'b1);
        run_op("read_and_write", 1'b1, 1'b1, 3'b011, 64'h8000_0000, 64'd0, 1, 2);
        exp_out(64'd0, 1'b0);
        run_op("non_mem", 1'b0, 1'b0, 3'b001, 64'h8000_0003, 64'd0, 1, 2);

        // Back-pressure on both bus request and writeback
        req_hold_cfg = 3;
        out_hold_cfg = 2;
        exp_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'hA5A5_5A5A_1234_5678);
        exp_out(64'hA5A5_5A5A_1234_5678, 1'b0);
        run_op("backpressure", 1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'd0, 6, 9);
        req_hold_cfg = 0;
        out_hold_cfg = 0;

        // Reset while waiting for a response; a late response must be dropped
        rsp_block = 1'b1;
        exp_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1111_2222_3333_4444);
        @(negedge clk); #1;
        in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b011; addr = 64'h8000_0010;
        @(negedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid),     64'd0);
        check("midrst_req_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        rsp_block = 1'b0;
        rsp_inject = 1'b1;
        @(negedge clk); #1;
        rsp_inject = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("stale_rsp_out_valid", 64'(out_valid), 64'd0);
            check("stale_rsp_in_ready",  64'(in_ready),  64'd1);
        end
        exp_req(1'b0, 64'h8000_0018, 64'd0, 8'h00, 64'h0F0E_0D0C_0B0A_0908);
        exp_out(64'h0F0E_0D0C_0B0A_0908, 1'b0);
        run_op("ld_after_rst", 1'b1, 1'b0, 3'b011, 64'h8000_0018, 64'd0, 3, 4);

        repeat (2) @(negedge clk);
        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        check("out_queue_drained", 64'(out_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
